// File: rtl/stage_id.sv
// RV32I instruction-decode stage: field/immediate decode, 32x32 register file with
// WB write port, load-use hazard detection and the ID/EX pipeline register.
module stage_id #(
    parameter logic [31:0] NOP_INSN  = 32'h0000_0013,
    parameter bit          BYPASS_WB = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instruction_i,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        wb_we_i,
    input  logic [4:0]  wb_rd_addr_i,
    input  logic [31:0] wb_rd_data_i,
    input  logic        ex_mem_read_i,
    input  logic [4:0]  ex_rd_addr_i,
    output logic        stall_o,
    output logic [31:0] pc_o,
    output logic [31:0] instruction_o,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] imm_o,
    output logic [3:0]  alu_op_o,
    output logic        alu_src_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    output logic [2:0]  mem_size_o,
    output logic        reg_we_o,
    output logic        branch_o,
    output logic        jump_o,
    output logic        illegal_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  mem_size;
        logic        reg_we;
        logic        branch;
        logic        jump;
        logic        illegal;
    } idex_t;

    function automatic logic signed [31:0] imm_i_f(input logic [31:0] insn);
        return {{20{insn[31]}}, insn[31:20]};
    endfunction

    function automatic logic signed [31:0] imm_s_f(input logic [31:0] insn);
        return {{20{insn[31]}}, insn[31:25], insn[11:7]};
    endfunction

    function automatic logic signed [31:0] imm_b_f(input logic [31:0] insn);
        return {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    endfunction

    function automatic logic signed [31:0] imm_u_f(input logic [31:0] insn);
        return {insn[31:12], 12'b0};
    endfunction

    function automatic logic signed [31:0] imm_j_f(input logic [31:0] insn);
        return {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
    endfunction

    logic [31:0] rf [32];
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1_f, rs2_f, rd_f;
    logic        use_rs1, use_rs2, we_raw;
    logic [31:0] rs1_rd, rs2_rd;
    idex_t       dec_p0, bubble_p0, idex_p1;

    assign opcode = instruction_i[6:0];
    assign funct3 = instruction_i[14:12];
    assign rs1_f  = instruction_i[19:15];
    assign rs2_f  = instruction_i[24:20];
    assign rd_f   = instruction_i[11:7];

    // Register file: x0 is never written, so its storage stays zero after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_we_i && wb_rd_addr_i != 5'd0) begin
            rf[wb_rd_addr_i] <= wb_rd_data_i;
        end
    end

    always_comb begin
        rs1_rd = rf[dec_p0.rs1_addr];
        rs2_rd = rf[dec_p0.rs2_addr];
        if (BYPASS_WB && wb_we_i && wb_rd_addr_i == dec_p0.rs1_addr) rs1_rd = wb_rd_data_i;
        if (BYPASS_WB && wb_we_i && wb_rd_addr_i == dec_p0.rs2_addr) rs2_rd = wb_rd_data_i;
        if (dec_p0.rs1_addr == 5'd0) rs1_rd = '0;
        if (dec_p0.rs2_addr == 5'd0) rs2_rd = '0;
    end

    // Stage p0: combinational decode of the instruction currently in ID.
    always_comb begin
        dec_p0      = '0;
        use_rs1     = 1'b0;
        use_rs2     = 1'b0;
        we_raw      = 1'b0;
        dec_p0.pc   = pc_i;
        dec_p0.insn = instruction_i;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                we_raw         = 1'b1;
                dec_p0.alu_src = 1'b1;
                dec_p0.imm     = imm_u_f(instruction_i);
            end
            OPC_JAL: begin
                we_raw      = 1'b1;
                dec_p0.jump = 1'b1;
                dec_p0.imm  = imm_j_f(instruction_i);
            end
            OPC_JALR: begin
                we_raw         = 1'b1;
                use_rs1        = 1'b1;
                dec_p0.jump    = 1'b1;
                dec_p0.alu_src = 1'b1;
                dec_p0.imm     = imm_i_f(instruction_i);
            end
            OPC_BRANCH: begin
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec_p0.branch = 1'b1;
                dec_p0.imm    = imm_b_f(instruction_i);
            end
            OPC_LOAD: begin
                we_raw          = 1'b1;
                use_rs1         = 1'b1;
                dec_p0.mem_read = 1'b1;
                dec_p0.alu_src  = 1'b1;
                dec_p0.mem_size = funct3;
                dec_p0.imm      = imm_i_f(instruction_i);
            end
            OPC_STORE: begin
                use_rs1          = 1'b1;
                use_rs2          = 1'b1;
                dec_p0.mem_write = 1'b1;
                dec_p0.alu_src   = 1'b1;
                dec_p0.mem_size  = funct3;
                dec_p0.imm       = imm_s_f(instruction_i);
            end
            OPC_OPIMM: begin
                we_raw         = 1'b1;
                use_rs1        = 1'b1;
                dec_p0.alu_src = 1'b1;
                dec_p0.imm     = imm_i_f(instruction_i);
                // Bit 30 is only an opcode bit for shifts; elsewhere it belongs to the immediate.
                dec_p0.alu_op  = {(funct3 == 3'b101) && instruction_i[30], funct3};
            end
            OPC_OP: begin
                we_raw        = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
                dec_p0.alu_op = {instruction_i[30], funct3};
            end
            OPC_MISC: begin
                dec_p0.imm = imm_i_f(instruction_i);
            end
            OPC_SYSTEM: begin
                we_raw     = (funct3 != 3'b000);
                dec_p0.imm = imm_i_f(instruction_i);
            end
            default: begin
                dec_p0.illegal = 1'b1;
            end
        endcase
        dec_p0.reg_we   = we_raw && (rd_f != 5'd0);
        dec_p0.rd_addr  = dec_p0.reg_we ? rd_f : 5'd0;
        dec_p0.rs1_addr = use_rs1 ? rs1_f : 5'd0;
        dec_p0.rs2_addr = use_rs2 ? rs2_f : 5'd0;
        dec_p0.rs1_data = rs1_rd;
        dec_p0.rs2_data = rs2_rd;
    end

    always_comb begin
        bubble_p0      = '0;
        bubble_p0.pc   = pc_i;
        bubble_p0.insn = NOP_INSN;
    end

    assign stall_o = ex_mem_read_i && (ex_rd_addr_i != 5'd0) &&
                     ((use_rs1 && rs1_f == ex_rd_addr_i) || (use_rs2 && rs2_f == ex_rd_addr_i));

    // Stage p1: ID/EX register. Flush beats a downstream stall, which beats a hazard bubble.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idex_p1      <= '0;
            idex_p1.insn <= NOP_INSN;
        end else if (flush_i) begin
            idex_p1 <= bubble_p0;
        end else if (!stall_i) begin
            idex_p1 <= stall_o ? bubble_p0 : dec_p0;
        end
    end

    assign pc_o          = idex_p1.pc;
    assign instruction_o = idex_p1.insn;
    assign rs1_data_o    = idex_p1.rs1_data;
    assign rs2_data_o    = idex_p1.rs2_data;
    assign rs1_addr_o    = idex_p1.rs1_addr;
    assign rs2_addr_o    = idex_p1.rs2_addr;
    assign rd_addr_o     = idex_p1.rd_addr;
    assign imm_o         = idex_p1.imm;
    assign alu_op_o      = idex_p1.alu_op;
    assign alu_src_o     = idex_p1.alu_src;
    assign mem_read_o    = idex_p1.mem_read;
    assign mem_write_o   = idex_p1.mem_write;
    assign mem_size_o    = idex_p1.mem_size;
    assign reg_we_o      = idex_p1.reg_we;
    assign branch_o      = idex_p1.branch;
    assign jump_o        = idex_p1.jump;
    assign illegal_o     = idex_p1.illegal;

endmodule

// File: tb/tb_stage_id.sv
// Bench for stage_id: hand-derived vector table driven through a scoreboard queue,
// plus reset, register-file bypass and x0 write sequences.
module tb_stage_id;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] instruction_i, pc_i;
    logic        stall_i, flush_i, wb_we_i, ex_mem_read_i;
    logic [4:0]  wb_rd_addr_i, ex_rd_addr_i;
    logic [31:0] wb_rd_data_i;
    logic        stall_o;
    logic [31:0] pc_o, instruction_o, rs1_data_o, rs2_data_o, imm_o;
    logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
    logic [3:0]  alu_op_o;
    logic        alu_src_o, mem_read_o, mem_write_o, reg_we_o, branch_o, jump_o, illegal_o;
    logic [2:0]  mem_size_o;

    stage_id dut (
        .clk_i(clk_i), .rst_i(rst_i), .instruction_i(instruction_i), .pc_i(pc_i),
        .stall_i(stall_i), .flush_i(flush_i), .wb_we_i(wb_we_i), .wb_rd_addr_i(wb_rd_addr_i),
        .wb_rd_data_i(wb_rd_data_i), .ex_mem_read_i(ex_mem_read_i), .ex_rd_addr_i(ex_rd_addr_i),
        .stall_o(stall_o), .pc_o(pc_o), .instruction_o(instruction_o), .rs1_data_o(rs1_data_o),
        .rs2_data_o(rs2_data_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rd_addr_o(rd_addr_o), .imm_o(imm_o), .alu_op_o(alu_op_o), .alu_src_o(alu_src_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_size_o(mem_size_o),
        .reg_we_o(reg_we_o), .branch_o(branch_o), .jump_o(jump_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

    // ctl = {alu_src, mem_read, mem_write, mem_size[2:0], reg_we, branch, jump, illegal}
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic [4:0]  a1, a2, rd;
        logic [31:0] d1, d2, imm;
        logic [3:0]  op;
        logic [9:0]  ctl;
    } exp_t;

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
        logic        flush, stall, exr;
        logic [4:0]  exrd;
        logic        exp_stall;
        exp_t        exp;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sbq[$];
    vec_t vq[$];

    function automatic exp_t mk(input logic [31:0] pc, insn, input logic [4:0] a1, a2, rd,
                                input logic [31:0] d1, d2, imm, input logic [3:0] op,
                                input logic [9:0] ctl);
        return {pc, insn, a1, a2, rd, d1, d2, imm, op, ctl};
    endfunction

    function automatic exp_t bub(input logic [31:0] pc);
        return mk(pc, 32'h13, 0, 0, 0, 0, 0, 0, 4'h0, 10'b0);
    endfunction

    function automatic exp_t actual();
        return {pc_o, instruction_o, rs1_addr_o, rs2_addr_o, rd_addr_o, rs1_data_o, rs2_data_o,
                imm_o, alu_op_o, alu_src_o, mem_read_o, mem_write_o, mem_size_o, reg_we_o,
                branch_o, jump_o, illegal_o};
    endfunction

    task automatic check_idex(input string name, input exp_t act, input exp_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    // Drive one ID cycle, check the combinational stall, then compare the registered result.
    task automatic drive_cycle(input string name, input logic [31:0] insn, pc,
                               input logic flush, stall, exr, input logic [4:0] exrd,
                               input logic exp_stall, input exp_t exp);
        exp_t e;
        instruction_i = insn; pc_i = pc; flush_i = flush; stall_i = stall;
        ex_mem_read_i = exr; ex_rd_addr_i = exrd;
        #1;
        check_bit({name, " stall_o"}, stall_o, exp_stall);
        sbq.push_back(exp);
        @(posedge clk_i); #1;
        wb_we_i = 1'b0;
        if (sbq.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sbq.pop_front();
            check_idex(name, actual(), e);
        end
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        wb_we_i = 1'b1; wb_rd_addr_i = a; wb_rd_data_i = d;
        @(posedge clk_i); #1;
        wb_we_i = 1'b0;
    endtask

    initial begin
        instruction_i = 32'h13; pc_i = '0; stall_i = 0; flush_i = 0;
        wb_we_i = 0; wb_rd_addr_i = '0; wb_rd_data_i = '0; ex_mem_read_i = 0; ex_rd_addr_i = '0;
        #2 rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        #1;
        check_idex("reset_state", actual(), bub(32'h0));
        check_bit("reset stall_o", stall_o, 1'b0);
        @(posedge clk_i); #1;

        for (int r = 1; r < 32; r++) begin
            logic [31:0] ins;
            ins = {7'b0, 5'(r), 5'(r), 3'b000, 5'd0, 7'b0110011};
            drive_cycle("reset_rf_zero", ins, 32'(r * 4), 0, 0, 0, 0, 0,
                        mk(32'(r * 4), ins, 5'(r), 5'(r), 0, 0, 0, 0, 4'h0, 10'b0));
        end

        instruction_i = 32'h13; flush_i = 0; stall_i = 0; ex_mem_read_i = 0;
        wb_write(5'd1, 32'h1111_1111);
        wb_write(5'd2, 32'h2222_2222);
        wb_write(5'd3, 32'h3333_3333);
        wb_write(5'd5, 32'h5555_5555);

        //            insn          pc         fl st exr exrd stall expected
        vq.push_back('{32'h00128313, 32'h100, 0, 0, 0, 5'd0, 0,
            mk(32'h100, 32'h00128313, 5, 0, 6, 32'h55555555, 0, 1, 4'h0, 10'b1_0_0_000_1_0_0_0)});
        vq.push_back('{32'h001283B3, 32'h104, 0, 0, 1, 5'd5, 1, bub(32'h104)});
        vq.push_back('{32'h001283B3, 32'h104, 0, 0, 0, 5'd5, 0,
            mk(32'h104, 32'h001283B3, 5, 1, 7, 32'h55555555, 32'h11111111, 0, 4'h0, 10'b0_0_0_000_1_0_0_0)});
        vq.push_back('{32'h00128393, 32'h108, 0, 0, 1, 5'd1, 0,
            mk(32'h108, 32'h00128393, 5, 0, 7, 32'h55555555, 0, 1, 4'h0, 10'b1_0_0_000_1_0_0_0)});
        vq.push_back('{32'h00028393, 32'h10C, 0, 0, 1, 5'd0, 0,
            mk(32'h10C, 32'h00028393, 5, 0, 7, 32'h55555555, 0, 0, 4'h0, 10'b1_0_0_000_1_0_0_0)});
        vq.push_back('{32'h00028393, 32'h110, 0, 0, 1, 5'd5, 1, bub(32'h110)});
        vq.push_back('{32'h00208463, 32'h114, 1, 1, 0, 5'd0, 0, bub(32'h114)});
        vq.push_back('{32'h00208463, 32'h114, 0, 1, 0, 5'd0, 0, bub(32'h114)});
        vq.push_back('{32'h00208463, 32'h114, 0, 0, 0, 5'd0, 0,
            mk(32'h114, 32'h00208463, 1, 2, 0, 32'h11111111, 32'h22222222, 8, 4'h0, 10'b0_0_0_000_0_1_0_0)});
        vq.push_back('{32'h00208463, 32'h118, 1, 0, 1, 5'd2, 1, bub(32'h118)});
        vq.push_back('{32'hFE21AE23, 32'h11C, 0, 0, 0, 5'd0, 0,
            mk(32'h11C, 32'hFE21AE23, 3, 2, 0, 32'h33333333, 32'h22222222, 32'hFFFFFFFC, 4'h0,
               10'b1_0_1_010_0_0_0_0)});
        vq.push_back('{32'hFFFFFFFF, 32'h120, 0, 0, 0, 5'd0, 0,
            mk(32'h120, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 4'h0, 10'b0_0_0_000_0_0_0_1)});
        vq.push_back('{32'h4030D413, 32'h124, 0, 0, 0, 5'd0, 0,
            mk(32'h124, 32'h4030D413, 1, 0, 8, 32'h11111111, 0, 32'h403, 4'hD, 10'b1_0_0_000_1_0_0_0)});
        vq.push_back('{32'h123454B7, 32'h128, 0, 0, 0, 5'd0, 0,
            mk(32'h128, 32'h123454B7, 0, 0, 9, 0, 0, 32'h12345000, 4'h0, 10'b1_0_0_000_1_0_0_0)});
        vq.push_back('{32'hFF9FF0EF, 32'h12C, 0, 0, 0, 5'd0, 0,
            mk(32'h12C, 32'hFF9FF0EF, 0, 0, 1, 0, 0, 32'hFFFFFFF8, 4'h0, 10'b0_0_0_000_1_0_1_0)});
        vq.push_back('{32'h00812503, 32'h130, 0, 0, 0, 5'd0, 0,
            mk(32'h130, 32'h00812503, 2, 0, 10, 32'h22222222, 0, 8, 4'h0, 10'b1_1_0_010_1_0_0_0)});
        vq.push_back('{32'h00000000, 32'h134, 0, 0, 0, 5'd0, 0,
            mk(32'h134, 32'h00000000, 0, 0, 0, 0, 0, 0, 4'h0, 10'b0_0_0_000_0_0_0_1)});
        vq.push_back('{32'h00508013, 32'h138, 0, 0, 0, 5'd0, 0,
            mk(32'h138, 32'h00508013, 1, 0, 0, 32'h11111111, 0, 5, 4'h0, 10'b1_0_0_000_0_0_0_0)});
        vq.push_back('{32'h00028393, 32'h13C, 0, 1, 1, 5'd5, 1,
            mk(32'h138, 32'h00508013, 1, 0, 0, 32'h11111111, 0, 5, 4'h0, 10'b1_0_0_000_0_0_0_0)});

        for (int i = 0; i < vq.size(); i++) begin
            drive_cycle($sformatf("vec%0d", i), vq[i].insn, vq[i].pc, vq[i].flush, vq[i].stall,
                        vq[i].exr, vq[i].exrd, vq[i].exp_stall, vq[i].exp);
        end

        wb_we_i = 1'b1; wb_rd_addr_i = 5'd5; wb_rd_data_i = 32'hDEADBEEF;
        drive_cycle("wb_bypass", 32'h00128313, 32'h200, 0, 0, 0, 0, 0,
            mk(32'h200, 32'h00128313, 5, 0, 6, 32'hDEADBEEF, 0, 1, 4'h0, 10'b1_0_0_000_1_0_0_0));
        drive_cycle("wb_stored", 32'h00128313, 32'h204, 0, 0, 0, 0, 0,
            mk(32'h204, 32'h00128313, 5, 0, 6, 32'hDEADBEEF, 0, 1, 4'h0, 10'b1_0_0_000_1_0_0_0));
        wb_we_i = 1'b1; wb_rd_addr_i = 5'd0; wb_rd_data_i = 32'hFFFFFFFF;
        drive_cycle("x0_bypass", 32'h00100313, 32'h208, 0, 0, 0, 0, 0,
            mk(32'h208, 32'h00100313, 0, 0, 6, 0, 0, 1, 4'h0, 10'b1_0_0_000_1_0_0_0));
        drive_cycle("x0_stored", 32'h00100313, 32'h20C, 0, 0, 0, 0, 0,
            mk(32'h20C, 32'h00100313, 0, 0, 6, 0, 0, 1, 4'h0, 10'b1_0_0_000_1_0_0_0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
